// File: rtl/sop_pkg.sv
// Shared definitions for the sum-of-products decimator: default width,
// a constant-foldable clog2 and the output buffer occupancy encoding.
package sop_pkg;

  localparam int WIDTH_DEFAULT = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << result) < value) begin
        result = result + 1;
      end
    end
    return result;
  endfunction

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/sop_out_fifo.sv
// Two-entry ready/valid output buffer. Head data and valid are registered;
// a push arriving while full with no pop is dropped and flagged on full_drop.
module sop_out_fifo
  import sop_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full_drop
);

  occ_t             state;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic             valid_q;
  logic             pop;

  assign pop        = valid_q && pop_ready;
  assign full_drop  = push && (state == TWO) && !pop;
  assign head_data  = head_q;
  assign head_valid = valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            head_q  <= push_data;
            valid_q <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q <= push_data;
          end else if (push) begin
            tail_q <= push_data;
            state  <= TWO;
          end else if (pop) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          // The pop frees a slot this cycle, so a simultaneous push still fits.
          if (pop) begin
            head_q <= tail_q;
            if (push) begin
              tail_q <= push_data;
            end else begin
              state <= ONE;
            end
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/sop_decimator.sv
// Accumulate-and-dump averager over DECIM valid samples, feeding a two-entry
// output buffer with sticky overflow and a saturating drop counter.
module sop_decimator
  import sop_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DECIM = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] x,
  input  logic                    in_valid,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic [7:0]              drop_count
);

  localparam int LOG2D = clog2(DECIM);
  localparam int AW    = WIDTH + LOG2D;

  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    sum;
  logic [LOG2D-1:0]        cnt;
  logic                    last;
  logic [WIDTH-1:0]        result;
  logic [WIDTH-1:0]        head_data;
  logic                    full_drop;

  // Widening by LOG2D bits means DECIM full-scale samples cannot wrap.
  assign sum    = acc + {{LOG2D{x[WIDTH-1]}}, x};
  assign last   = in_valid && (cnt == LOG2D'(DECIM - 1));
  assign result = WIDTH'(sum >>> LOG2D);

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (last) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_valid) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (full_drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  sop_out_fifo #(
    .WIDTH (WIDTH)
  ) u_out_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (last),
    .push_data  (result),
    .pop_ready  (out_ready),
    .head_data  (head_data),
    .head_valid (out_valid),
    .full_drop  (full_drop)
  );

  assign out_data = head_data;

endmodule

// File: tb/tb_sop_decimator.sv
// Directed bench for sop_decimator: expected averages are queued as blocks are
// driven and compared whenever the DUT hands a result to the consumer.
module tb_sop_decimator;

  logic               clk;
  logic               reset;
  logic signed [15:0] x;
  logic               in_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               overflow;
  logic [7:0]         drop_count;

  int          checks;
  int          errors;
  logic [15:0] exp_q[$];

  sop_decimator #(
    .WIDTH (16),
    .DECIM (4)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .x          (x),
    .in_valid   (in_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle; at the falling edge compare any result being accepted.
  task automatic step(input logic [15:0] xv, input logic v);
    logic [15:0] want;
    x        = xv;
    in_valid = v;
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      $display("txn out_data=%h queued=%0d", out_data, exp_q.size());
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output got %h expected none", out_data);
      end
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        chk("out_data", out_data, want);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic [15:0] want, input bit keep);
    if (keep) exp_q.push_back(want);
    step(a, 1'b1);
    step(b, 1'b1);
    step(c, 1'b1);
    step(d, 1'b1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    x         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    step(16'h0, 1'b0);
    chk("reset_out_valid", 16'(out_valid), 16'h0);
    chk("reset_out_data", out_data, 16'h0);
    chk("reset_overflow", 16'(overflow), 16'h0);
    chk("reset_drop_count", 16'(drop_count), 16'h0);
    reset = 1'b0;

    // 1,2,3,4 -> 2, valid exactly one cycle after the fourth sample
    send_block(16'd1, 16'd2, 16'd3, 16'd4, 16'd2, 1'b1);
    chk("latency_valid", 16'(out_valid), 16'h1);
    step(16'h0, 1'b0);
    chk("single_cycle_valid", 16'(out_valid), 16'h0);

    // Negative average truncates toward -inf
    send_block(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFE, 1'b1);
    step(16'h0, 1'b0);

    // Full-scale extremes must not wrap inside the accumulator
    send_block(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    send_block(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b1);
    step(16'h0, 1'b0);
    step(16'h0, 1'b0);

    // Gaps in in_valid: garbage x on invalid cycles must be ignored
    exp_q.push_back(16'd6);
    step(16'd5, 1'b1);
    step(16'd100, 1'b0);
    step(16'd6, 1'b1);
    step(16'd100, 1'b0);
    step(16'd7, 1'b1);
    step(16'd100, 1'b0);
    chk("gap_no_early_valid", 16'(out_valid), 16'h0);
    step(16'd8, 1'b1);
    chk("gap_valid", 16'(out_valid), 16'h1);
    step(16'h0, 1'b0);
    chk("gap_single_output", 16'(out_valid), 16'h0);

    // Stalled consumer: two results buffered, third dropped
    out_ready = 1'b0;
    send_block(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b1);
    send_block(16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 1'b1);
    send_block(16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 1'b0);
    chk("stall_out_valid", 16'(out_valid), 16'h1);
    chk("stall_head", out_data, 16'd1);
    chk("stall_overflow", 16'(overflow), 16'h1);
    chk("stall_drop_count", 16'(drop_count), 16'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) begin
      step(16'h0, 1'b0);
    end
    chk("drain_out_valid", 16'(out_valid), 16'h0);
    chk("drain_queue_empty", 16'(exp_q.size()), 16'h0);
    chk("sticky_overflow", 16'(overflow), 16'h1);

    // Reset mid-block discards partial sum and clears the overflow record
    step(16'd50, 1'b1);
    step(16'd50, 1'b1);
    reset = 1'b1;
    step(16'h0, 1'b0);
    reset = 1'b0;
    chk("rst_overflow", 16'(overflow), 16'h0);
    chk("rst_drop_count", 16'(drop_count), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    send_block(16'd8, 16'd8, 16'd8, 16'd8, 16'd8, 1'b1);
    chk("post_rst_valid", 16'(out_valid), 16'h1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      step(16'h0, 1'b0);
    end
    step(16'h0, 1'b0);
    chk("final_queue_empty", 16'(exp_q.size()), 16'h0);
    chk("final_out_valid", 16'(out_valid), 16'h0);
    chk("final_overflow", 16'(overflow), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sop_decimator.md
Name: sop_decimator

Overview:
- Downstream stage of the sum-of-products filter (mm_sop1/mkSOP1/mc_sop1 family).
- Consumes the filter's 16-bit signed output y, one sample per clock when in_valid is high.
- Averages each block of DECIM consecutive valid samples (accumulate-and-dump).
- Presents each average on a ready/valid output through a 2-entry buffer, with overflow accounting.

Parameters:
- WIDTH, 16, sample width in and out (signed two's complement).
- DECIM, 4, decimation factor; must be a power of two, 2..256.
- LOG2D, clog2(DECIM), derived; not overridable.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- x  in  WIDTH  signed filter output sample.
- in_valid  in  1  x is valid this cycle; no backpressure on the input side.
- out_data  out  WIDTH  signed average; head of the output buffer.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- overflow  out  1  sticky; set when a result was dropped.
- drop_count  out  8  number of dropped results, saturates at 255.

Behaviour:
- Reset (synchronous, active-high): clears acc, cnt, buffer (empty), out_valid, out_data, overflow and drop_count to 0.
  - A reset mid-block discards the partial accumulation.
  - Reset has priority over all other events in the same cycle.
- Accumulator:
  - acc is signed, WIDTH+LOG2D bits, so it cannot overflow.
  - cnt runs 0..DECIM-1.
  - in_valid low: acc and cnt hold.
  - in_valid high and cnt < DECIM-1: acc <= acc + sext(x); cnt <= cnt+1.
  - in_valid high and cnt == DECIM-1:
    - result = (acc + sext(x)) >>> LOG2D, arithmetic shift, i.e. truncation toward -inf, low WIDTH bits.
    - Push result; acc <= 0; cnt <= 0.
- Latency: the result is visible on out_data/out_valid the cycle after the DECIM-th valid sample is sampled, when the buffer is empty.
- Output buffer: 2-entry FIFO, occupancy states EMPTY, ONE, TWO.
  - Pop occurs when out_valid && out_ready.
  - EMPTY:
    - push -> ONE.
    - out_ready is ignored.
  - ONE:
    - push only -> TWO.
    - pop only -> EMPTY.
    - push+pop -> ONE, with the new entry at head.
  - TWO:
    - pop only -> ONE.
    - push+pop -> TWO; the push is accepted because the pop frees a slot in the same cycle.
    - push without pop -> result dropped, state stays TWO, overflow <= 1, drop_count increments unless already 255.
  - out_data equals the head entry whenever out_valid = 1.
  - When out_valid = 0, out_data holds its last value; it is 0 after reset. Benches must not check out_data while out_valid = 0.
  - out_valid and out_data are registered, with no combinational path from out_ready.
  - Ordering is strict FIFO, with no reordering and no duplication.
- overflow and drop_count are cleared only by reset.

Decomposition:
- Package sop_pkg holds:
  - the WIDTH default (16);
  - the clog2 function;
  - the occupancy enum {EMPTY, ONE, TWO}.
- One sub-module, sop_out_fifo: 2-entry ready/valid buffer with a push-when-full drop indication.
  - Parameter: WIDTH.
  - Ports: clock, reset, push, push_data, pop_ready, head_data, head_valid, full_drop.
- Top level: accumulator, counter, and overflow/drop counters.

Test Plan:
- DECIM=4, out_ready=1, x=1,2,3,4 on consecutive valid cycles -> out_data=2 with out_valid high for exactly one cycle, one cycle after x=4.
- x=-1,-1,-1,-2 -> out_data=0xFFFE (-2, truncation toward -inf).
- x=0x7FFF four times, then 0x8000 four times -> 0x7FFF then 0x8000, with no wrap in acc.
- in_valid toggled 1,0,1,0 across samples 5,6,7,8 -> a single output of 6; cnt holds on invalid cycles.
- out_ready=0, then 3 full blocks (results 1,2,3) -> out_valid=1, buffer holds 1,2, third dropped, overflow=1, drop_count=1. Then out_ready=1 -> 1 then 2 delivered, then out_valid=0.
- Reset asserted after 2 of 4 samples, then 4 fresh samples of 8 -> single output 8, with overflow=0 and drop_count=0.
